// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares one single-port backing memory between the instruction fetch port
// and the data (load/store) port. One transaction is in flight at a time.
// Data requests win over fetch; stores win over loads. A fetch whose
// response is made stale by a pipeline redirect (flush) is completed on the
// memory side but its fetchValid strobe is suppressed.
//
// Optional feature: define ARB_STARVE_GUARD_EN to enable the fetch
// starvation guard. Once STARVE_LIMIT data grants have been made while a
// fetch waits, the next arbitration goes to fetch. Without the macro,
// data priority is strict and the guard counter does not exist.
module memory_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  // Fetch port
  input  logic                  fetchRequest,
  input  logic [ADDR_WIDTH-1:0] fetchAddress,
  input  logic                  flush,
  output logic [31:0]           fetchData,
  output logic                  fetchValid,
  // Data port
  input  logic                  loadRequest,
  input  logic                  storeValid,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           storeData,
  input  logic [3:0]            byteEnable,
  output logic [31:0]           loadData,
  output logic                  loadDataValid,
  output logic                  storeComplete,
  // Backing memory
  output logic                  memRequest,
  output logic                  memWrite,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [31:0]           memWriteData,
  output logic [3:0]            memByteEnable,
  input  logic                  memReady,
  input  logic                  memReadValid,
  input  logic [31:0]           memReadData
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_READ = 2'd2
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  // Transaction control state
  state_t r_state;
  state_t w_state_next;
  owner_t r_owner;
  owner_t w_owner_next;
  logic   r_kill;
  logic   w_kill_next;

  // Registered outputs and their next values
  logic                  r_mem_request;
  logic                  w_mem_request_next;
  logic                  r_mem_write;
  logic                  w_mem_write_next;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [ADDR_WIDTH-1:0] w_mem_address_next;
  logic [31:0]           r_mem_wdata;
  logic [31:0]           w_mem_wdata_next;
  logic [3:0]            r_mem_be;
  logic [3:0]            w_mem_be_next;
  logic [31:0]           r_fetch_data;
  logic [31:0]           w_fetch_data_next;
  logic                  r_fetch_valid;
  logic                  w_fetch_valid_next;
  logic [31:0]           r_load_data;
  logic [31:0]           w_load_data_next;
  logic                  r_load_valid;
  logic                  w_load_valid_next;
  logic                  r_store_complete;
  logic                  w_store_complete_next;

  // Arbitration
  logic w_data_req;
  logic w_starved;
  logic w_grant_fetch;
  logic w_grant_data;
  logic w_fetch_owned;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] r_starve_cnt;

  // Fetch is owed the next grant once the guard counter reaches its limit.
  assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
`else
  assign w_starved = 1'b0;
`endif

  assign w_data_req    = storeValid | loadRequest;
  assign w_grant_fetch = fetchRequest & (~w_data_req | w_starved);
  assign w_grant_data  = w_data_req & ~w_grant_fetch;
  assign w_fetch_owned = (r_owner == OWN_FETCH);

`ifdef ARB_STARVE_GUARD_EN
  // Count data grants made while fetch waits; clear on fetch grant or when fetch is idle; saturate.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (!fetchRequest) begin
      r_starve_cnt <= '0;
    end else if ((r_state == ST_IDLE) && w_grant_fetch) begin
      r_starve_cnt <= '0;
    end else if ((r_state == ST_IDLE) && w_grant_data && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end
`endif

  // Next-state logic: arbitration in IDLE, bus handshake in ISSUE, response capture in WAIT_READ.
  always_comb begin
    w_state_next          = r_state;
    w_owner_next          = r_owner;
    w_kill_next           = r_kill;
    w_mem_request_next    = r_mem_request;
    w_mem_write_next      = r_mem_write;
    w_mem_address_next    = r_mem_address;
    w_mem_wdata_next      = r_mem_wdata;
    w_mem_be_next         = r_mem_be;
    w_fetch_data_next     = r_fetch_data;
    w_fetch_valid_next    = 1'b0;
    w_load_data_next      = r_load_data;
    w_load_valid_next     = 1'b0;
    w_store_complete_next = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // A flush here has nothing to kill; the kill bit is always clear in IDLE.
        w_kill_next = 1'b0;
        if (w_grant_data) begin
          w_owner_next       = OWN_DATA;
          w_mem_write_next   = storeValid;
          w_mem_address_next = address;
          w_mem_wdata_next   = storeValid ? storeData : 32'h0000_0000;
          w_mem_be_next      = storeValid ? byteEnable : 4'b1111;
          w_mem_request_next = 1'b1;
          w_state_next       = ST_ISSUE;
        end else if (w_grant_fetch) begin
          w_owner_next       = OWN_FETCH;
          w_mem_write_next   = 1'b0;
          w_mem_address_next = fetchAddress;
          w_mem_wdata_next   = 32'h0000_0000;
          w_mem_be_next      = 4'b1111;
          w_mem_request_next = 1'b1;
          w_state_next       = ST_ISSUE;
        end else begin
          w_state_next       = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        if (flush && w_fetch_owned) begin
          w_kill_next = 1'b1;
        end else begin
          w_kill_next = r_kill;
        end
        if (memReady) begin
          w_mem_request_next = 1'b0;
          if (r_mem_write) begin
            w_store_complete_next = 1'b1;
            w_kill_next           = 1'b0;
            w_state_next          = ST_IDLE;
          end else begin
            w_state_next = ST_WAIT_READ;
          end
        end else begin
          w_state_next = ST_ISSUE;
        end
      end

      ST_WAIT_READ: begin
        if (memReadValid) begin
          w_state_next = ST_IDLE;
          w_kill_next  = 1'b0;
          if (!w_fetch_owned) begin
            w_load_data_next  = memReadData;
            w_load_valid_next = 1'b1;
          end else if (!(r_kill || flush)) begin
            // A flush in the same cycle as the data still kills it.
            w_fetch_data_next  = memReadData;
            w_fetch_valid_next = 1'b1;
          end else begin
            w_fetch_valid_next = 1'b0;
          end
        end else begin
          w_state_next = ST_WAIT_READ;
          if (flush && w_fetch_owned) begin
            w_kill_next = 1'b1;
          end else begin
            w_kill_next = r_kill;
          end
        end
      end

      default: begin
        w_state_next       = ST_IDLE;
        w_kill_next        = 1'b0;
        w_mem_request_next = 1'b0;
      end
    endcase
  end

  // Transaction state register: FSM state, owner and kill bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_FETCH;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      r_kill  <= w_kill_next;
    end
  end

  // Output registers: latched bus fields, response data and one-cycle strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mem_request    <= 1'b0;
      r_mem_write      <= 1'b0;
      r_mem_address    <= '0;
      r_mem_wdata      <= 32'h0000_0000;
      r_mem_be         <= 4'b0000;
      r_fetch_data     <= 32'h0000_0000;
      r_fetch_valid    <= 1'b0;
      r_load_data      <= 32'h0000_0000;
      r_load_valid     <= 1'b0;
      r_store_complete <= 1'b0;
    end else begin
      r_mem_request    <= w_mem_request_next;
      r_mem_write      <= w_mem_write_next;
      r_mem_address    <= w_mem_address_next;
      r_mem_wdata      <= w_mem_wdata_next;
      r_mem_be         <= w_mem_be_next;
      r_fetch_data     <= w_fetch_data_next;
      r_fetch_valid    <= w_fetch_valid_next;
      r_load_data      <= w_load_data_next;
      r_load_valid     <= w_load_valid_next;
      r_store_complete <= w_store_complete_next;
    end
  end

  assign memRequest    = r_mem_request;
  assign memWrite      = r_mem_write;
  assign memAddress    = r_mem_address;
  assign memWriteData  = r_mem_wdata;
  assign memByteEnable = r_mem_be;
  assign fetchData     = r_fetch_data;
  assign fetchValid    = r_fetch_valid;
  assign loadData      = r_load_data;
  assign loadDataValid = r_load_valid;
  assign storeComplete = r_store_complete;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
// Scoreboard bench for memory_arbiter: requesters push the expected response
// (read from a reference word array updated by store byte lanes) into per-port
// queues; a monitor pops and compares whenever a response strobe appears.
// A behavioural backing memory with programmable or random latency answers
// the memory port. Directed scenarios cover latency, stalls, priority, flush,
// starvation (ARB_STARVE_GUARD_EN aware) and reset during ISSUE.
module tb_memory_arbiter;

  logic        clock;
  logic        reset;
  logic        fetchRequest;
  logic [31:0] fetchAddress;
  logic        flush;
  logic [31:0] fetchData;
  logic        fetchValid;
  logic        loadRequest;
  logic        storeValid;
  logic [31:0] address;
  logic [31:0] storeData;
  logic [3:0]  byteEnable;
  logic [31:0] loadData;
  logic        loadDataValid;
  logic        storeComplete;
  logic        memRequest;
  logic        memWrite;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic [3:0]  memByteEnable;
  logic        memReady;
  logic        memReadValid;
  logic [31:0] memReadData;

  memory_arbiter #(.ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .fetchRequest(fetchRequest), .fetchAddress(fetchAddress), .flush(flush),
    .fetchData(fetchData), .fetchValid(fetchValid),
    .loadRequest(loadRequest), .storeValid(storeValid), .address(address),
    .storeData(storeData), .byteEnable(byteEnable),
    .loadData(loadData), .loadDataValid(loadDataValid), .storeComplete(storeComplete),
    .memRequest(memRequest), .memWrite(memWrite), .memAddress(memAddress),
    .memWriteData(memWriteData), .memByteEnable(memByteEnable),
    .memReady(memReady), .memReadValid(memReadValid), .memReadData(memReadData)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [31:0] sim_mem [128];   // contents as written through the DUT
  logic [31:0] ref_mem [128];   // reference contents from the request stream

  logic [31:0] q_fetch [$];
  logic [31:0] q_load  [$];
  int          q_store_idx [$];
  logic [31:0] q_store_val [$];
  bit          grant_log [$];   // 1 = fetch-region grant

  int fetch_cnt = 0, load_cnt = 0;
  int fetch_cyc = 0, load_cyc = 0;

  int lat_ready = 0, lat_rv = 0;
  bit rand_lat  = 1'b0;
  bit inject_rv = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc = cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Behavioural backing memory
  initial begin
    int          wait_cnt;
    int          rd_cnt;
    bit          rd_pend;
    logic [31:0] rd_data;
    int          idx;
    wait_cnt = 0; rd_cnt = 0; rd_pend = 1'b0; rd_data = 32'h0;
    memReady = 1'b0; memReadValid = 1'b0; memReadData = 32'h0;
    forever begin
      @(negedge clock);
      memReadValid = 1'b0;
      if (reset) begin
        memReady = 1'b0; wait_cnt = 0; rd_pend = 1'b0; rd_cnt = 0;
      end else begin
        if (inject_rv) begin
          memReadValid = 1'b1; memReadData = 32'hBAD0_BAD0; inject_rv = 1'b0;
        end
        if (rd_pend) begin
          if (rd_cnt == 0) begin
            memReadValid = 1'b1; memReadData = rd_data; rd_pend = 1'b0;
          end else begin
            rd_cnt--;
          end
        end
        if (memReady) begin
          memReady = 1'b0;
        end else if (memRequest) begin
          if (wait_cnt >= lat_ready) begin
            memReady = 1'b1;
            wait_cnt = 0;
            idx = int'(memAddress[8:2]);
            grant_log.push_back(memAddress < 32'h100);
            if (memWrite) begin
              for (int b = 0; b < 4; b++)
                if (memByteEnable[b]) sim_mem[idx][8*b +: 8] = memWriteData[8*b +: 8];
            end else begin
              rd_pend = 1'b1; rd_cnt = lat_rv; rd_data = sim_mem[idx];
            end
            if (rand_lat) begin
              lat_ready = $urandom_range(0, 3);
              lat_rv    = $urandom_range(0, 3);
            end
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  // Scoreboard monitor
  initial forever begin
    @(negedge clock);
    if (fetchValid) begin
      if (q_fetch.size() == 0) check("fetch_unexpected", 32'(fetchValid), 32'd0);
      else check("fetch_data", fetchData, q_fetch.pop_front());
      fetch_cnt++; fetch_cyc = cyc;
    end
    if (loadDataValid) begin
      if (q_load.size() == 0) check("load_unexpected", 32'(loadDataValid), 32'd0);
      else check("load_data", loadData, q_load.pop_front());
      load_cnt++; load_cyc = cyc;
    end
    if (storeComplete) begin
      if (q_store_idx.size() == 0) check("store_unexpected", 32'(storeComplete), 32'd0);
      else check("store_mem", sim_mem[q_store_idx.pop_front()], q_store_val.pop_front());
    end
  end

  task automatic start_fetch(input logic [31:0] a);
    fetchAddress = a; fetchRequest = 1'b1;
    q_fetch.push_back(ref_mem[a[8:2]]);
  endtask

  task automatic start_load(input logic [31:0] a);
    address = a; loadRequest = 1'b1; storeValid = 1'b0;
    q_load.push_back(ref_mem[a[8:2]]);
  endtask

  task automatic start_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int i;
    i = int'(a[8:2]);
    address = a; storeData = d; byteEnable = be; storeValid = 1'b1; loadRequest = 1'b0;
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[i][8*b +: 8] = d[8*b +: 8];
    q_store_idx.push_back(i);
    q_store_val.push_back(ref_mem[i]);
  endtask

  task automatic wait_fetch(input int limit);
    int t = 0;
    do begin @(negedge clock); t++; end while (!fetchValid && t < limit);
    check("fetch_done", 32'(fetchValid), 32'd1);
    fetchRequest = 1'b0;
  endtask

  task automatic wait_data(input int limit);
    int t = 0;
    do begin @(negedge clock); t++; end while (!(loadDataValid || storeComplete) && t < limit);
    check("data_done", 32'(loadDataValid | storeComplete), 32'd1);
    loadRequest = 1'b0; storeValid = 1'b0;
  endtask

  task automatic fetch_rand(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      start_fetch({23'd0, 7'($urandom_range(0, 63)), 2'b00});
      wait_fetch(300);
    end
  endtask

  task automatic data_rand(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      repeat ($urandom_range(0, 3)) @(negedge clock);
      a = {23'd0, 1'b1, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 1) == 1) start_store(a, $urandom, 4'($urandom_range(0, 15)));
      else start_load(a);
      wait_data(300);
    end
  endtask

  initial begin
    int c0, fc, fpos;
    reset = 1'b1; fetchRequest = 1'b0; fetchAddress = 32'h0; flush = 1'b0;
    loadRequest = 1'b0; storeValid = 1'b0; address = 32'h0; storeData = 32'h0;
    byteEnable = 4'b0000;
    for (int i = 0; i < 128; i++) begin
      sim_mem[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
      ref_mem[i] = sim_mem[i];
    end
    sim_mem[16] = 32'h0000_0013; ref_mem[16] = 32'h0000_0013;   // 0x40
    sim_mem[32] = 32'h0010_0093; ref_mem[32] = 32'h0010_0093;   // 0x80

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_memRequest", 32'(memRequest), 32'd0);
    check("rst_memAddress", memAddress, 32'd0);
    check("rst_fetchData", fetchData, 32'd0);
    check("rst_loadData", loadData, 32'd0);
    check("rst_strobes", {29'd0, fetchValid, loadDataValid, storeComplete}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Fetch latency and back-to-back fetch after IDLE
    lat_ready = 0; lat_rv = 0;
    start_fetch(32'h40);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      check($sformatf("fetch_lat_k%0d", k), 32'(fetchValid), 32'(k == 3));
      if (k == 1) check("fetch_memAddress", memAddress, 32'h40);
    end
    fetchRequest = 1'b0;
    start_fetch(32'h40);
    @(negedge clock);
    check("fetch2_memRequest", 32'(memRequest), 32'd1);
    repeat (2) @(negedge clock);
    check("fetch2_valid", 32'(fetchValid), 32'd1);
    fetchRequest = 1'b0;

    // Store with a 3-cycle memReady stall
    lat_ready = 3;
    start_store(32'h100, 32'hDEAD_BEEF, 4'b0011);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      check($sformatf("st_req_k%0d", k), 32'(memRequest), 32'(k <= 4));
      check($sformatf("st_done_k%0d", k), 32'(storeComplete), 32'(k == 5));
      if (k <= 4) begin
        check("st_memWrite", 32'(memWrite), 32'd1);
        check("st_memByteEnable", 32'(memByteEnable), 32'h3);
        check("st_memAddress", memAddress, 32'h100);
        check("st_memWriteData", memWriteData, 32'hDEAD_BEEF);
      end
    end
    storeValid = 1'b0;
    @(negedge clock);
    check("st_single_pulse", 32'(storeComplete), 32'd0);

    // Simultaneous fetch and load: load first, fetch follows
    lat_ready = 0; lat_rv = 0;
    c0 = cyc;
    start_fetch(32'h20);
    start_load(32'h104);
    fork
      wait_fetch(50);
      wait_data(50);
    join
    #1;
    check("sim_load_cycle", 32'(load_cyc - c0), 32'd3);
    check("sim_fetch_cycle", 32'(fetch_cyc - c0), 32'd6);

    // Flush during WAIT_READ, then flush coincident with memReadValid
    for (int v = 0; v < 2; v++) begin
      lat_rv = (v == 0) ? 3 : 0;
      fc = fetch_cnt;
      start_fetch((v == 0) ? 32'h44 : 32'h48);
      repeat (2) @(negedge clock);
      flush = 1'b1; fetchRequest = 1'b0;
      void'(q_fetch.pop_back());
      @(negedge clock);
      flush = 1'b0;
      repeat (6) @(negedge clock);
      check($sformatf("flush_suppress_%0d", v), 32'(fetch_cnt - fc), 32'd0);
    end
    lat_rv = 0;
    start_fetch(32'h80);
    wait_fetch(20);

    // Starvation behaviour under continuous loads
    @(negedge clock);
    grant_log.delete();
    start_fetch(32'h0C);
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          start_load(32'h180 + 32'(i * 4));
          wait_data(60);
        end
      end
      wait_fetch(200);
    join
    #1;
`ifdef ARB_STARVE_GUARD_EN
    fpos = 4;
`else
    fpos = 6;
`endif
    check("starve_grants", 32'(grant_log.size()), 32'd7);
    for (int i = 0; i < 7; i++)
      check($sformatf("starve_grant_%0d", i),
            (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF_FFFF, 32'(i == fpos));

    // Reset while in ISSUE, then a stray memReadValid
    @(negedge clock);
    lat_ready = 20;
    fc = fetch_cnt;
    fetchAddress = 32'h40; fetchRequest = 1'b1;
    @(negedge clock);
    check("rsti_memRequest", 32'(memRequest), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("rsti_memRequest0", 32'(memRequest), 32'd0);
    check("rsti_memAddress0", memAddress, 32'd0);
    check("rsti_fetchData0", fetchData, 32'd0);
    check("rsti_loadData0", loadData, 32'd0);
    check("rsti_wr_be0", {27'd0, memWrite, memByteEnable}, 32'd0);
    check("rsti_wdata0", memWriteData, 32'd0);
    reset = 1'b0; fetchRequest = 1'b0;
    inject_rv = 1'b1;
    repeat (3) @(negedge clock);
    check("rsti_no_strobe", {29'd0, fetchValid, loadDataValid, storeComplete}, 32'd0);
    check("rsti_no_fetch", 32'(fetch_cnt - fc), 32'd0);
    check("rsti_idle", 32'(memRequest), 32'd0);
    lat_ready = 0;

    // Randomized concurrent traffic with random memory latency
    rand_lat = 1'b1;
    fork
      fetch_rand(40);
      data_rand(40);
    join
    rand_lat = 1'b0;
    repeat (10) @(negedge clock);
    check("end_q_fetch", 32'(q_fetch.size()), 32'd0);
    check("end_q_load", 32'(q_load.size()), 32'd0);
    check("end_q_store", 32'(q_store_idx.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares one single-port backing memory between the Fetch instruction port and the Memory-stage data port, replacing the split Imem/Dmem pair in Top. The block holds one transaction in flight, arbitrates with data-over-fetch priority plus an optional starvation guard, and returns responses on per-requester valid strobes. It discards fetch responses made stale by a pipeline redirect.

## Interface
- ADDR_WIDTH, 32, byte address width on all ports
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits (guard builds only)
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- fetchRequest  in  1  instruction read request; held until fetchValid or flush
- fetchAddress  in  ADDR_WIDTH  instruction address, word aligned
- flush  in  1  redirect (controlReset or taken branch); kills outstanding fetch
- fetchData  out  32  instruction word
- fetchValid  out  1  one-cycle pulse, fetchData valid
- loadRequest  in  1  data read request; held until loadDataValid
- storeValid  in  1  data write request; held until storeComplete
- address  in  ADDR_WIDTH  data address
- storeData  in  32  write data
- byteEnable  in  4  write byte lanes
- loadData  out  32  read data
- loadDataValid  out  1  one-cycle pulse
- storeComplete  out  1  one-cycle pulse
- memRequest  out  1  backing-memory request, held until memReady
- memWrite  out  1  1 = write, 0 = read
- memAddress  out  ADDR_WIDTH  latched address
- memWriteData  out  32  latched store data
- memByteEnable  out  4  latched lanes; 4'b1111 on reads
- memReady  in  1  request accepted this cycle
- memReadValid  in  1  read data returned
- memReadData  in  32  read data

## Operation
- FSM states: IDLE, ISSUE, WAIT_READ. Owner register: FETCH or DATA.
- In IDLE, pick a winner from the requests sampled this cycle, then latch owner, address, data, lanes, and the write flag. Move to ISSUE on the next cycle.
- Priority: data beats fetch. Within data, storeValid beats loadRequest. A load held during a store is serviced later.
- ISSUE: memRequest=1. On memReady, a read goes to WAIT_READ and a write goes to IDLE with storeComplete pulsed.
- WAIT_READ: on memReadValid, register memReadData into fetchData or loadData, pulse the owner's valid, and return to IDLE.
- Flush with owner FETCH (ISSUE or WAIT_READ): set the kill bit and finish the transaction, but suppress fetchValid. A flush in IDLE has no effect. A flush in the same cycle as memReadValid kills the response.
- The kill bit clears on return to IDLE.
- Requests arriving while not in IDLE wait. No request is lost while its requester holds it.
- memReadValid outside WAIT_READ is ignored.

## Timing
- Reset: state IDLE, owner FETCH, counter 0, kill 0. All outputs are 0, including fetchData and loadData.
- Reset during any state aborts the transaction. No response pulse follows.
- Outputs are registered. All strobes last exactly one cycle.
- Read: request at cycle N, memRequest at N+1. If memReady is high at N+1 and memReadValid at N+2, the valid pulse comes at N+3.
- Write: request at N, memRequest at N+1, memReady at N+1, storeComplete at N+2.
- Back-to-back: the next arbitration happens in the IDLE cycle after a response. The minimum spacing is 3 cycles per read and 2 per write.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A counter counts data grants made while fetchRequest is high.
  - It clears on a fetch grant or when fetchRequest is low.
  - When the counter equals STARVE_LIMIT and both sides request, fetch wins.
  - The counter saturates and never wraps.
- Undefined: strict data priority. Fetch can starve indefinitely. The counter logic is absent.

## Test plan
- Fetch only: fetchAddress=0x40, memReady=1, memReadValid one cycle later with data 0x00000013. fetchValid pulses at request+3 with fetchData=0x13. The next fetch is issued after IDLE.
- Store with byteEnable=4'b0011, address 0x100, data 0xDEADBEEF, memReady stalled 3 cycles. memRequest and memByteEnable are held stable, storeComplete pulses once, and memWrite=1.
- Simultaneous fetchRequest and loadRequest: the load is issued first (loadDataValid), then the fetch (fetchValid), with no lost request.
- Flush asserted in WAIT_READ of a fetch: memReadValid arrives and fetchValid stays 0. A subsequent fetch to 0x80 completes normally.
- Starvation (ARB_STARVE_GUARD_EN, STARVE_LIMIT=4): continuous loads plus fetchRequest give 4 load grants, then 1 fetch grant, then loads resume. Without the macro, no fetch grant occurs.
- Reset asserted in ISSUE: the next cycle is IDLE with all outputs 0, and a late memReadValid produces no strobe.
